pak_dsp_cfg_ctrl: RTL and testbench

PAK_DSP_CFG_CTRL -- requirements
Module: pak_dsp_cfg_ctrl

---
 rtl/pak_dsp_cfg_ctrl_if.sv | 28 ++
 rtl/pak_dsp_cfg_ctrl.sv | 118 +++++++++++
 tb/tb_pak_dsp_cfg_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/pak_dsp_cfg_ctrl_if.sv
// rtl/pak_dsp_cfg_ctrl_if.sv - coefficient stream and pak_dsp register bus bundle
interface pak_dsp_cfg_ctrl_if #(
   parameter int COEFF_WIDTH = 16
);
   logic                   start;
   logic                   abort;
   logic [15:0]            ctrl_word;
   logic [COEFF_WIDTH-1:0] coeff_in;
   logic                   coeff_valid;
   logic                   coeff_ready;
   logic [5:0]             addr;
   logic                   write_en;
   logic [15:0]            wdata;
   logic [15:0]            rdata;
   logic                   busy;
   logic                   done;
   logic                   err;

   modport slave (
      input  start, abort, ctrl_word, coeff_in, coeff_valid, rdata,
      output coeff_ready, addr, write_en, wdata, busy, done, err
   );

   modport master (
      output start, abort, ctrl_word, coeff_in, coeff_valid, rdata,
      input  coeff_ready, addr, write_en, wdata, busy, done, err
   );
endinterface

// File: rtl/pak_dsp_cfg_ctrl.sv
// rtl/pak_dsp_cfg_ctrl.sv - loads N coefficients into pak_dsp with readback check, then writes the control word
module pak_dsp_cfg_ctrl #(
   parameter int N           = 8,
   parameter int COEFF_WIDTH = 16,
   parameter int COEFF_BASE  = 32,
   parameter int CTRL_ADDR   = 0
) (
   input logic                clk,
   input logic                arst_n,
   pak_dsp_cfg_ctrl_if.slave  bus
);
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_WRITE,
      S_CHECK,
      S_CTRL,
      S_DONE
   } state_t;

   state_t                 r_state;
   logic [IW-1:0]          r_index;
   logic [COEFF_WIDTH-1:0] r_coeff;
   logic [15:0]            r_ctrl;
   logic                   r_err;

   logic [5:0]             w_coeff_addr;
   logic [5:0]             w_addr;
   logic [15:0]            w_wdata;
   logic                   w_write_en;
   logic                   w_coeff_ready;
   logic                   w_done;

   assign w_coeff_addr = 6'(COEFF_BASE) + 6'(r_index);

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_state <= S_IDLE;
         r_index <= '0;
         r_coeff <= '0;
         r_ctrl  <= '0;
         r_err   <= 1'b0;
      end else if (r_state != S_IDLE && bus.abort) begin
         // abort wins over every transition and leaves err untouched
         r_state <= S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start && !bus.abort) begin
                  r_state <= S_LOAD;
                  r_ctrl  <= bus.ctrl_word;
                  r_index <= '0;
                  r_err   <= 1'b0;
               end
            end
            S_LOAD: begin
               if (bus.coeff_valid) begin
                  r_coeff <= bus.coeff_in;
                  r_state <= S_WRITE;
               end
            end
            S_WRITE: r_state <= S_CHECK;
            S_CHECK: begin
               if (bus.rdata != 16'(r_coeff)) begin
                  r_err <= 1'b1;
               end
               if (r_index == IW'(N - 1)) begin
                  r_state <= S_CTRL;
               end else begin
                  r_index <= r_index + 1'b1;
                  r_state <= S_LOAD;
               end
            end
            S_CTRL:  r_state <= S_DONE;
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // bus outputs are pure decodes of the state registers so reset clears them at once
   always_comb begin
      w_addr        = 6'd0;
      w_wdata       = 16'd0;
      w_write_en    = 1'b0;
      w_coeff_ready = 1'b0;
      w_done        = 1'b0;
      case (r_state)
         S_LOAD:  w_coeff_ready = 1'b1;
         S_WRITE: begin
            w_addr     = w_coeff_addr;
            w_wdata    = 16'(r_coeff);
            w_write_en = 1'b1;
         end
         S_CHECK: begin
            w_addr  = w_coeff_addr;
            w_wdata = 16'(r_coeff);
         end
         S_CTRL: begin
            w_addr     = 6'(CTRL_ADDR);
            w_wdata    = r_ctrl;
            w_write_en = 1'b1;
         end
         S_DONE:  w_done = 1'b1;
         default: w_done = 1'b0;
      endcase
   end

   assign bus.addr        = w_addr;
   assign bus.wdata       = w_wdata;
   assign bus.write_en    = w_write_en;
   assign bus.coeff_ready = w_coeff_ready;
   assign bus.done        = w_done;
   assign bus.busy        = (r_state != S_IDLE);
   assign bus.err         = r_err;
endmodule

// File: tb/tb_pak_dsp_cfg_ctrl.sv
// tb/tb_pak_dsp_cfg_ctrl.sv - randomized directed bench for pak_dsp_cfg_ctrl against a register model
module tb_pak_dsp_cfg_ctrl;
   localparam int N  = 8;
   localparam int CW = 16;
   localparam int CB = 32;
   localparam int CA = 0;

   logic clk    = 1'b0;
   logic arst_n = 1'b0;
   always #5 clk = ~clk;

   pak_dsp_cfg_ctrl_if #(.COEFF_WIDTH(CW)) bus ();

   pak_dsp_cfg_ctrl #(
      .N(N), .COEFF_WIDTH(CW), .COEFF_BASE(CB), .CTRL_ADDR(CA)
   ) dut (
      .clk(clk),
      .arst_n(arst_n),
      .bus(bus)
   );

   logic [15:0] mem [64];
   int          bad_addr = -1;

   assign bus.rdata = mem[bus.addr] ^ ((int'(bus.addr) == bad_addr) ? 16'h0001 : 16'h0000);
   always @(posedge clk) if (bus.write_en) mem[bus.addr] <= bus.wdata;

   int passes = 0;
   int fails  = 0;
   int total  = 0;

   logic [CW-1:0] coef [N];
   logic [31:0]   obs_q [$];
   int            done_cnt, done_cyc, err_first, overlap;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [26:0] snap();
      return {bus.busy, bus.done, bus.err, bus.write_en, bus.coeff_ready, bus.addr, bus.wdata};
   endfunction

   function automatic int wr_cycle(input int k, input int gap_k, input int gap_len);
      return 3 * k + 2 + ((gap_k >= 0 && k >= gap_k) ? gap_len : 0);
   endfunction

   task automatic run_seq(input logic [15:0] ctrl, input int gap_k, input int gap_len,
                          input int abort_idx, input bit start_wr, input string nm);
      int nacc = 0, gap_used = 0, prev_wr = -1, abort_cyc = -1;
      bit started_wr = 0;
      int limit = 3 * N + gap_len + 30;
      int nexp, nchk, bad_k, ecyc;
      logic [31:0] erec;
      bit exp_err;
      obs_q.delete();
      done_cnt = 0; done_cyc = -1; err_first = -1; overlap = 0;
      @(negedge clk);
      bus.start = 1'b1; bus.abort = 1'b0; bus.ctrl_word = ctrl;
      bus.coeff_valid = 1'b1; bus.coeff_in = coef[0];
      @(posedge clk);
      for (int cyc = 1; cyc < limit; cyc++) begin
         @(negedge clk);
         bus.start = 1'b0; bus.abort = 1'b0; bus.ctrl_word = ~ctrl;
         if (cyc == 1) chk({nm, "_busy_errclr"}, 32'({bus.busy, bus.err}), 32'b10);
         if (bus.write_en) obs_q.push_back({10'(cyc), bus.addr, bus.wdata});
         if (bus.write_en && bus.coeff_ready) overlap++;
         if (bus.done) begin done_cnt++; done_cyc = cyc; end
         if (bus.err && err_first < 0) err_first = cyc;
         if (abort_cyc >= 0 && cyc == abort_cyc + 1)
            chk({nm, "_abort_busy"}, 32'(bus.busy), 32'd0);
         if (start_wr && bus.write_en && !started_wr) begin bus.start = 1'b1; started_wr = 1; end
         if (abort_idx >= 0 && prev_wr == CB + abort_idx && abort_cyc < 0) begin
            bus.abort = 1'b1; abort_cyc = cyc;
         end
         prev_wr = bus.write_en ? int'(bus.addr) : -1;
         if (bus.coeff_ready && nacc == gap_k && gap_used < gap_len) begin
            bus.coeff_valid = 1'b0; gap_used++;
         end else begin
            bus.coeff_valid = 1'b1;
            bus.coeff_in = (nacc < N) ? coef[nacc] : CW'($urandom);
            if (bus.coeff_ready) nacc++;
         end
         if (done_cyc >= 0 && cyc > done_cyc + 2) break;
         if (abort_cyc >= 0 && cyc > abort_cyc + 6) break;
      end
      bus.coeff_valid = 1'b0;

      nexp = (abort_idx >= 0) ? abort_idx + 1 : N + 1;
      nchk = (abort_idx >= 0) ? abort_idx : N;
      chk({nm, "_nwrites"}, 32'(obs_q.size()), 32'(nexp));
      for (int k = 0; k < nexp && k < obs_q.size(); k++) begin
         if (k < N) erec = {10'(wr_cycle(k, gap_k, gap_len)), 6'(CB + k), 16'(coef[k])};
         else       erec = {10'(3 * N + 1 + gap_len), 6'(CA), ctrl};
         chk($sformatf("%s_wr%0d", nm, k), obs_q[k], erec);
      end
      chk({nm, "_done_cnt"}, 32'(done_cnt), (abort_idx >= 0) ? 32'd0 : 32'd1);
      if (abort_idx < 0) chk({nm, "_done_cyc"}, 32'(done_cyc), 32'(3 * N + 2 + gap_len));
      chk({nm, "_overlap"}, 32'(overlap), 32'd0);
      bad_k   = bad_addr - CB;
      exp_err = (bad_addr >= 0) && bad_k >= 0 && bad_k < nchk;
      ecyc    = exp_err ? wr_cycle(bad_k, gap_k, gap_len) + 2 : -1;
      chk({nm, "_err"}, 32'(bus.err), 32'(exp_err));
      chk({nm, "_err_first"}, 32'(err_first), 32'(ecyc));
   endtask

   task automatic rand_coefs();
      for (int i = 0; i < N; i++) coef[i] = CW'($urandom);
   endtask

   task automatic reset_mid(input int nwr, input bit in_write, input string nm);
      int seen = 0;
      bit hit = 0;
      @(negedge clk);
      bus.start = 1'b1; bus.ctrl_word = 16'(CW'($urandom));
      bus.coeff_valid = 1'b1; bus.coeff_in = coef[0];
      @(posedge clk);
      for (int cyc = 1; cyc < 60 && !hit; cyc++) begin
         @(negedge clk);
         bus.start = 1'b0;
         if (seen == nwr && (in_write ? bus.write_en : bus.coeff_ready)) hit = 1;
         else if (bus.write_en) seen++;
      end
      chk({nm, "_reached"}, 32'(hit), 32'd1);
      #2 arst_n = 1'b0;
      #1 chk({nm, "_async_clear"}, 32'(snap()), 32'd0);
      @(negedge clk);
      arst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk({nm, "_idle_wait"}, 32'(snap()), 32'd0);
   endtask

   initial begin
      bus.start = 1'b0; bus.abort = 1'b0; bus.ctrl_word = '0;
      bus.coeff_in = '0; bus.coeff_valid = 1'b0;
      for (int i = 0; i < 64; i++) mem[i] = 16'h0;
      #1 chk("reset_state", 32'(snap()), 32'd0);
      #20;
      @(negedge clk);
      arst_n = 1'b1;

      for (int i = 0; i < N; i++) coef[i] = CW'(i + 1);
      run_seq(16'd64, -1, 0, -1, 0, "basic");

      rand_coefs();
      bad_addr = 35;
      run_seq(16'($urandom), -1, 0, -1, 0, "corrupt");
      bad_addr = -1;
      repeat (2) @(negedge clk);
      chk("err_sticky_idle", 32'({bus.busy, bus.err}), 32'b01);

      rand_coefs();
      run_seq(16'($urandom), 2, 5, -1, 0, "gap");

      rand_coefs();
      run_seq(16'($urandom), -1, 0, 4, 0, "abort");

      rand_coefs();
      run_seq(16'($urandom), -1, 0, -1, 1, "start_busy");

      @(negedge clk);
      bus.start = 1'b1; bus.abort = 1'b1;
      @(negedge clk);
      bus.start = 1'b0; bus.abort = 1'b0;
      chk("start_abort_idle", 32'(bus.busy), 32'd0);

      rand_coefs();
      reset_mid(2, 1'b0, "rst_load2");
      run_seq(16'($urandom), -1, 0, -1, 0, "after_rst");
      reset_mid(5, 1'b1, "rst_write5");

      for (int r = 0; r < 3; r++) begin
         rand_coefs();
         bad_addr = ($urandom_range(0, 1) == 1) ? CB + int'($urandom_range(0, N - 1)) : -1;
         run_seq(16'($urandom), int'($urandom_range(0, N - 1)), int'($urandom_range(1, 4)),
                 -1, 0, $sformatf("rnd%0d", r));
      end
      bad_addr = -1;

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end
endmodule
